aux_capture: RTL and testbench
==============================

# aux_capture

Receiving end of the DSP core's auxiliary output port (`aux_out_addr`/`aux_out_data`/`aux_out_en`). It collects AUXOUT writes issued during one audio frame into a ping-pong buffer. At each frame boundary it streams the completed frame to a downstream consumer, such as a metering or host-readback link, over a valid/ready handshake. It sits between one `dsp_core` instance and the host interface logic, in the core clock domain.

## Interface
- `SAMPLE_WIDTH`, 36: width of the signed aux data word (matches the core sample width).
- `SAMPLE_ADDR_WIDTH`, 10: width of the aux address.
- `CAPTURE_DEPTH`, 16: slots captured per frame; addresses 0..CAPTURE_DEPTH-1. Must be a power of two and ≥2.
- `clk`  in  1  core clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `aux_out_addr`  in  SAMPLE_ADDR_WIDTH  aux write address from the core.
- `aux_out_data`  in  SAMPLE_WIDTH  signed aux write data from the core.
- `aux_out_en`  in  1  aux write strobe; one write per cycle when high.
- `frame_sync`  in  1  single-cycle pulse marking the end of a sample frame.
- `out_data`  out  SAMPLE_WIDTH  streamed slot value.
- `out_addr`  out  $clog2(CAPTURE_DEPTH)  slot index of `out_data`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts the word when high together with `out_valid`.
- `out_last`  out  1  high with the final slot (index CAPTURE_DEPTH-1).
- `overrun`  out  1  sticky flag; set when a `frame_sync` arrives while streaming.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- There are two banks, each holding CAPTURE_DEPTH words plus a per-slot written-mask. `wr_bank` selects the bank currently being filled; the other bank is the read bank.
- Aux writes:
  - A write with `aux_out_en=1` and `aux_out_addr < CAPTURE_DEPTH` stores `aux_out_data` into the write bank and sets that slot's mask bit.
  - A write with `aux_out_addr ≥ CAPTURE_DEPTH` is ignored.
  - Repeated writes to the same slot in one frame: the last one wins.
- Controller states are IDLE and STREAM.
- IDLE + `frame_sync`:
  - Toggle `wr_bank`.
  - Clear the new write bank's mask.
  - Go to STREAM with the slot counter at 0.
- STREAM:
  - Present slot `counter` of the read bank. Slots whose mask bit is clear output 0.
  - The counter advances on each handshake (`out_valid && out_ready`).
  - The handshake on slot CAPTURE_DEPTH-1 returns the controller to IDLE.
- STREAM + `frame_sync` (overrun):
  - No swap; `overrun` is set.
  - The write bank's mask is cleared, so that frame's captured data is discarded and the next frame starts fresh.
  - Streaming continues undisturbed.
- Simultaneous aux write and `frame_sync`: the write belongs to the closing frame, i.e. it lands in the bank being swapped out. On an overrun it is discarded along with the rest of that frame.
- Simultaneous `overrun_clr` and a new overrun: the set wins.
- Handshake rules:
  - `out_data`, `out_addr` and `out_last` are held stable while `out_valid=1 && out_ready=0`.
  - `out_valid` never drops without a handshake, except on reset.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE; `wr_bank`=0.
  - All masks are cleared; bank data is don't-care, since it is masked.
- Stream outputs are registered. `out_valid` rises 1 cycle after the `frame_sync` cycle that causes the swap, presenting slot 0.
- With `out_ready` held high, a frame drains in exactly CAPTURE_DEPTH consecutive cycles. The earliest next accepted `frame_sync` is the cycle after the final handshake.
- A write accepted in cycle N is visible in the stream of the frame closed at or after N.
- Reset asserted mid-stream: streaming aborts immediately, all outputs go to 0, and both banks are treated as empty.

## Configuration
- `AUX_CAPTURE_PEAK_EN` defined: each slot holds the peak magnitude for the frame instead of the last value.
  - A write stores max(stored, |data|).
  - The first write of a frame stores |data|.
  - |most-negative| saturates to the largest positive value.
  - Streamed values are non-negative.
- `AUX_CAPTURE_PEAK_EN` undefined: last-value capture as described in Operation.

## Structure
- The shared package `dsp_pkg` holds the `SAMPLE_WIDTH` / `SAMPLE_ADDR_WIDTH` defaults and the `aux_capture_state_t` enum {IDLE, STREAM}.
- Sub-module `aux_capture_bank`: one bank's storage, mask and write/peak-update logic, with a combinational read port. It is instantiated twice.

## Test plan
- Frame capture:
  - Stimulus: writes 0x1 to slot 0 and 0x5 to slot 3 (CAPTURE_DEPTH=16), `frame_sync`, `out_ready`=1.
  - Required: 16 words; slot 0=1, slot 3=5, others 0; `out_last` only on index 15.
- Backpressure:
  - Stimulus: `out_ready` toggled 1/0 each cycle.
  - Required: outputs stable during stalls; the frame completes in 31 cycles with no word lost or duplicated.
- Overrun:
  - Stimulus: `frame_sync` while streaming, with `out_ready`=0.
  - Required: `overrun`=1; the current stream continues; the next frame contains only post-overrun writes; `overrun_clr` returns the flag to 0.
- Boundary write:
  - Stimulus: a write to addr 16 with data 7, plus a write to slot 2 in the same cycle as `frame_sync`.
  - Required: addr 16 is not seen; slot 2 appears in the frame just closed.
- Reset mid-stream:
  - Stimulus: assert `reset` at slot 5.
  - Required: `out_valid`=0 and `overrun`=0 at once; the first frame after reset shows only new writes.
- Peak mode (`AUX_CAPTURE_PEAK_EN`):
  - Stimulus: writes -3, 2, then the most-negative value to slot 1.
  - Required: slot 1 streams the maximum positive value; with only -3 and 2 written, it streams 3.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: default sample/address widths and the aux capture
// controller state type.
package dsp_pkg;

  localparam int SAMPLE_WIDTH_DEFAULT      = 36;
  localparam int SAMPLE_ADDR_WIDTH_DEFAULT = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } aux_capture_state_t;

endpackage

// File: rtl/aux_capture_bank.sv
// One capture bank: slot storage, per-slot written-mask and write/peak-update logic.
// AUX_CAPTURE_PEAK_EN selects peak-magnitude capture instead of last-value capture.
module aux_capture_bank
  import dsp_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH_DEFAULT,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] mask;
  logic [WIDTH-1:0] wr_val;
  logic             wr_commit;

  // A clear in the same cycle discards the write along with the rest of the frame.
  assign wr_commit = wr_en && !clr;

`ifdef AUX_CAPTURE_PEAK_EN
  function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] neg;
    neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    if (!v[WIDTH-1]) begin
      sat_abs = v;
    end else if (neg[WIDTH-1]) begin
      sat_abs = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_abs = neg;
    end
  endfunction

  logic [WIDTH-1:0] mag;

  always_comb begin
    mag = sat_abs(wr_data);
    if (mask[wr_addr] && (mem[wr_addr] > mag)) begin
      wr_val = mem[wr_addr];
    end else begin
      wr_val = mag;
    end
  end
`else
  assign wr_val = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[wr_addr] <= wr_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (clr) begin
      mask <= '0;
    end else if (wr_en) begin
      mask[wr_addr] <= 1'b1;
    end
  end

  // Forward a same-cycle write so a slot loaded at the swap edge includes it.
  always_comb begin
    if (wr_commit && (wr_addr == rd_addr)) begin
      rd_data = wr_val;
    end else if (mask[rd_addr]) begin
      rd_data = mem[rd_addr];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/aux_capture.sv
// Ping-pong capture of DSP aux writes per frame, streamed out over valid/ready.
// Define AUX_CAPTURE_PEAK_EN for peak-magnitude capture.
module aux_capture
  import dsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH      = SAMPLE_WIDTH_DEFAULT,
  parameter int SAMPLE_ADDR_WIDTH = SAMPLE_ADDR_WIDTH_DEFAULT,
  parameter int CAPTURE_DEPTH     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [SAMPLE_ADDR_WIDTH-1:0]     aux_out_addr,
  input  logic [SAMPLE_WIDTH-1:0]          aux_out_data,
  input  logic                             aux_out_en,
  input  logic                             frame_sync,
  output logic [SAMPLE_WIDTH-1:0]          out_data,
  output logic [$clog2(CAPTURE_DEPTH)-1:0] out_addr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             overrun,
  input  logic                             overrun_clr
);

  localparam int            CW        = $clog2(CAPTURE_DEPTH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(CAPTURE_DEPTH - 1);

  aux_capture_state_t state, state_next;
  logic                    wr_bank, wr_bank_next;
  logic [CW-1:0]           counter, counter_next;
  logic                    out_valid_next, out_last_next, overrun_next;
  logic [SAMPLE_WIDTH-1:0] out_data_next;
  logic                    rd_bank;
  logic [CW-1:0]           rd_addr;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic [SAMPLE_WIDTH-1:0] bank_rd [2];
  logic                    in_range, swap, ovr;

  assign in_range = aux_out_en && (aux_out_addr < SAMPLE_ADDR_WIDTH'(CAPTURE_DEPTH));
  assign swap     = (state == IDLE) && frame_sync;
  assign ovr      = (state == STREAM) && frame_sync;
  assign out_addr = counter;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    aux_capture_bank #(
      .WIDTH (SAMPLE_WIDTH),
      .DEPTH (CAPTURE_DEPTH)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .clr     ((swap && (wr_bank != 1'(b))) || (ovr && (wr_bank == 1'(b)))),
      .wr_en   (in_range && (wr_bank == 1'(b))),
      .wr_addr (aux_out_addr[CW-1:0]),
      .wr_data (aux_out_data),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

  // In IDLE, look ahead at slot 0 of the bank about to close.
  always_comb begin
    if (state == STREAM) begin
      rd_bank = ~wr_bank;
      rd_addr = counter + CW'(1);
    end else begin
      rd_bank = wr_bank;
      rd_addr = '0;
    end
  end

  assign rd_data = bank_rd[rd_bank];

  always_comb begin
    state_next     = state;
    wr_bank_next   = wr_bank;
    counter_next   = counter;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    out_last_next  = out_last;
    case (state)
      IDLE: begin
        if (frame_sync) begin
          state_next     = STREAM;
          wr_bank_next   = ~wr_bank;
          counter_next   = '0;
          out_valid_next = 1'b1;
          out_data_next  = rd_data;
          out_last_next  = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      STREAM: begin
        if (out_valid && out_ready) begin
          if (counter == LAST_SLOT) begin
            state_next     = IDLE;
            counter_next   = '0;
            out_valid_next = 1'b0;
            out_data_next  = '0;
            out_last_next  = 1'b0;
          end else begin
            counter_next  = counter + CW'(1);
            out_data_next = rd_data;
            out_last_next = (counter + CW'(1)) == LAST_SLOT;
          end
        end else begin
          state_next = STREAM;
        end
      end
      default: begin
        state_next     = IDLE;
        counter_next   = '0;
        out_valid_next = 1'b0;
        out_data_next  = '0;
        out_last_next  = 1'b0;
      end
    endcase
  end

  // Sticky overrun: a new overrun takes priority over a same-cycle clear.
  always_comb begin
    if (ovr) begin
      overrun_next = 1'b1;
    end else if (overrun_clr) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_bank   <= 1'b0;
      counter   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      wr_bank   <= wr_bank_next;
      counter   <= counter_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      out_last  <= out_last_next;
      overrun   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_aux_capture.sv
// Self-checking bench for aux_capture against a frame-level reference model.
// Build with AUX_CAPTURE_PEAK_EN to also exercise peak capture.
module tb_aux_capture;

  localparam int W = 36;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    aux_out_addr = '0;
  logic [W-1:0]  aux_out_data = '0;
  logic          aux_out_en = 1'b0;
  logic          frame_sync = 1'b0;
  logic [W-1:0]  out_data;
  logic [3:0]    out_addr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  aux_capture dut (
    .clk          (clk),
    .reset        (reset),
    .aux_out_addr (aux_out_addr),
    .aux_out_data (aux_out_data),
    .aux_out_en   (aux_out_en),
    .frame_sync   (frame_sync),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  // Reference model: the frame being collected, frames waiting to be streamed, overrun flag.
  logic [W-1:0] cur_val [D];
  bit           cur_has [D];
  logic [W-1:0] exp_q [$];
  bit           mdl_ovr;

  // Observed / expected per-cycle views: {valid, overrun, last, addr, data}.
  logic [42:0]  obs_vec, exp_vec;
  int           dut_hs;
  logic [W-1:0] got [D];
  int           total = 0;
  int           bad = 0;

  function automatic logic [W-1:0] mdl_mag(input logic [W-1:0] d);
    longint v, maxpos;
    logic [63:0] r;
    maxpos = (longint'(1) <<< (W - 1)) - 1;
    v = longint'($signed(d));
    if (v < 0) v = -v;
    if (v > maxpos) v = maxpos;
    r = 64'(v);
    return r[W-1:0];
  endfunction

  task automatic model_write(input int a, input logic [W-1:0] d);
    logic [W-1:0] m;
    if (a < D) begin
`ifdef AUX_CAPTURE_PEAK_EN
      m = mdl_mag(d);
      if (!cur_has[a] || (m > cur_val[a])) cur_val[a] = m;
`else
      m = d;
      cur_val[a] = m;
`endif
      cur_has[a] = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < D; i++) begin
      cur_has[i] = 1'b0;
      cur_val[i] = '0;
    end
    mdl_ovr = 1'b0;
  endtask

  task automatic clear_got();
    for (int i = 0; i < D; i++) got[i] = 36'hABCDE1234;
  endtask

  // One clock cycle: sample outputs, drive inputs, advance the model for this cycle.
  task automatic step(input bit fs, input bit en, input int a, input logic [W-1:0] d,
                      input bit rdy, input bit clr);
    bit busy;
    bit ovr_set;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      exp_vec = {1'b1, mdl_ovr, exp_q.size() == 1, 4'(D - exp_q.size()), exp_q[0]};
      obs_vec = {out_valid, overrun, out_last, out_addr, out_data};
    end else begin
      exp_vec = {1'b0, mdl_ovr, 41'd0};
      obs_vec = {out_valid, overrun, 41'd0};
    end
    if (out_valid && rdy) begin
      dut_hs++;
      got[out_addr] = out_data;
    end
    frame_sync   = fs;
    aux_out_en   = en;
    aux_out_addr = 10'(a);
    aux_out_data = d;
    out_ready    = rdy;
    overrun_clr  = clr;
    busy    = exp_q.size() != 0;
    ovr_set = 1'b0;
    if (busy && rdy) void'(exp_q.pop_front());
    if (en) model_write(a, d);
    if (fs) begin
      if (busy) ovr_set = 1'b1;
      else for (int i = 0; i < D; i++) exp_q.push_back(cur_has[i] ? cur_val[i] : '0);
      for (int i = 0; i < D; i++) cur_has[i] = 1'b0;
    end
    if (ovr_set) mdl_ovr = 1'b1;
    else if (clr) mdl_ovr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    total++; if (out_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", out_addr); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", out_last); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_frame_capture();
    int lastcnt = 0;
    clear_got();
    step(0, 1, 0, 36'h1, 1, 0);
    step(0, 1, 3, 36'h5, 1, 0);
    step(1, 0, 0, '0, 1, 0);
    dut_hs = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, 0);
      if (obs_vec[42] && obs_vec[40]) lastcnt++;
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL capture_cycle%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    total++; if (dut_hs !== 16) begin bad++; $display("FAIL capture_words: got %0d want 16", dut_hs); end
    total++; if (lastcnt !== 1) begin bad++; $display("FAIL capture_last_count: got %0d want 1", lastcnt); end
    total++; if (got[0] !== 36'h1) begin bad++; $display("FAIL capture_slot0: got %h want 1", got[0]); end
    total++; if (got[3] !== 36'h5) begin bad++; $display("FAIL capture_slot3: got %h want 5", got[3]); end
    total++; if (got[9] !== 36'h0) begin bad++; $display("FAIL capture_slot9: got %h want 0", got[9]); end
  endtask

  task automatic test_backpressure();
    int vcount = 0;
    bit prev_stall = 1'b0;
    logic [42:0] prev_vec = '0;
    for (int s = 0; s < 4; s++) step(0, 1, $urandom_range(0, 15), 36'($urandom), 1, 0);
    step(1, 0, 0, '0, 0, 0);
    dut_hs = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, '0, (k % 2) == 0, 0);
      if (obs_vec[42]) vcount++;
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL bp_cycle%0d: got %h want %h", k, obs_vec, exp_vec); end
      if (prev_stall) begin
        total++; if (obs_vec !== prev_vec) begin bad++; $display("FAIL bp_stable%0d: got %h want %h", k, obs_vec, prev_vec); end
      end
      prev_stall = obs_vec[42] && ((k % 2) != 0);
      prev_vec   = obs_vec;
    end
    total++; if (vcount !== 31) begin bad++; $display("FAIL bp_frame_cycles: got %0d want 31", vcount); end
    total++; if (dut_hs !== 16) begin bad++; $display("FAIL bp_words: got %0d want 16", dut_hs); end
  endtask

  task automatic test_overrun();
    step(0, 1, 4, 36'h44, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    step(0, 1, 4, 36'h99, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, '0, 0, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL ovr_stall%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    total++; if (obs_vec[41] !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", obs_vec[41]); end
    step(0, 1, 6, 36'h66, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL ovr_drain%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    clear_got();
    step(1, 0, 0, '0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL ovr_next%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    total++; if (got[4] !== 36'h0) begin bad++; $display("FAIL ovr_discard_slot4: got %h want 0", got[4]); end
    total++; if (got[6] !== 36'h66) begin bad++; $display("FAIL ovr_keep_slot6: got %h want 66", got[6]); end
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 0);
    total++; if (obs_vec[41] !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", obs_vec[41]); end
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 1, 0);
    total++; if (obs_vec[41] !== 1'b1) begin bad++; $display("FAIL ovr_set_beats_clr: got %b want 1", obs_vec[41]); end
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, (k == 18));
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL ovr_tail%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_boundary();
    clear_got();
    step(0, 1, 16, 36'h7, 1, 0);
    step(1, 1, 2, 36'h22, 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL bnd_cycle%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    total++; if (got[0] !== 36'h0) begin bad++; $display("FAIL bnd_addr16_ignored: got %h want 0", got[0]); end
    total++; if (got[2] !== 36'h22) begin bad++; $display("FAIL bnd_sync_write: got %h want 22", got[2]); end
  endtask

  task automatic test_reset_mid_stream();
    bit reached = 1'b0;
    step(0, 1, 1, 36'h11, 1, 0);
    step(1, 0, 0, '0, 1, 0);
    step(1, 0, 0, '0, 1, 0);
    step(0, 1, 7, 36'h77, 1, 0);
    for (int k = 0; k < 20 && !reached; k++) begin
      step(0, 0, 0, '0, 1, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rst_pre%0d: got %h want %h", k, obs_vec, exp_vec); end
      if (obs_vec[42] && (obs_vec[39:36] == 4'd4)) reached = 1'b1;
    end
    total++; if (!reached) begin bad++; $display("FAIL rst_reach_slot4: got 0 want 1"); end
    @(posedge clk);
    #1;
    total++; if ({out_valid, out_addr, overrun} !== {1'b1, 4'd5, 1'b1}) begin
      bad++; $display("FAIL rst_at_slot5: got %b/%0d/%b want 1/5/1", out_valid, out_addr, overrun);
    end
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
    model_reset();
    frame_sync = 1'b0; aux_out_en = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_got();
    step(0, 1, 9, 36'h99, 1, 0);
    step(1, 0, 0, '0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rst_post%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    total++; if (got[1] !== 36'h0) begin bad++; $display("FAIL rst_old_slot1: got %h want 0", got[1]); end
    total++; if (got[7] !== 36'h0) begin bad++; $display("FAIL rst_old_slot7: got %h want 0", got[7]); end
    total++; if (got[9] !== 36'h99) begin bad++; $display("FAIL rst_new_slot9: got %h want 99", got[9]); end
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int k = 0; k < 400; k++) begin
      r = {$urandom(), $urandom()};
      step($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 20),
           r[W-1:0], $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rand_cycle%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, '0, 1, 1);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rand_drain%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
  endtask

`ifdef AUX_CAPTURE_PEAK_EN
  task automatic test_peak();
    logic [W-1:0] most_neg = {1'b1, {(W-1){1'b0}}};
    clear_got();
    step(0, 1, 1, -36'sd3, 1, 0);
    step(0, 1, 1, 36'sd2, 1, 0);
    step(1, 0, 0, '0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL peak_a%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    total++; if (got[1] !== 36'd3) begin bad++; $display("FAIL peak_abs3: got %h want 3", got[1]); end
    clear_got();
    step(0, 1, 1, -36'sd3, 1, 0);
    step(0, 1, 1, 36'sd2, 1, 0);
    step(0, 1, 1, most_neg, 1, 0);
    step(1, 0, 0, '0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, '0, 1, 0);
      total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL peak_b%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    total++; if (got[1] !== 36'h7FFFFFFFF) begin bad++; $display("FAIL peak_sat: got %h want 7ffffffff", got[1]); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dut_hs = 0;
    test_reset();
    test_frame_capture();
    test_backpressure();
    test_overrun();
    test_boundary();
    test_reset_mid_stream();
    test_random();
`ifdef AUX_CAPTURE_PEAK_EN
    test_peak();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
